aes_cipher_core: RTL and testbench

- Iterative AES-128 encryption datapath; sits directly downstream of the key-expansion stage and consumes its 1408-bit round-key bundle.
- Runs one round per clock: initial AddRoundKey, 9 full rounds, then the final round without MixColumns.
- Delivers a 128-bit ciphertext with a valid pulse.
- Serves the top-level AES wrapper; the key-expansion stage's round-key output connects directly to round_keys.

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_round.sv | 49 ++++
 rtl/aes_cipher_core.sv | 118 +++++++++++
 tb/tb_aes_cipher_core.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions: block/round constants, cipher FSM state encoding,
// the forward S-box and the GF(2^8) helpers used by MixColumns. The
// key-expansion stage takes its S-box from this package as well.
// Ports: none (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_NR    = 10;
    localparam int unsigned AES_RK_W  = 1408;

    // HOLD is only entered when AES_CIPHER_OUT_HANDSHAKE_EN is defined.
    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        HOLD
    } fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_round.sv
// -----------------------------------------------------------------------------
// aes_round
// Combinational AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// MixColumns is bypassed when final_round is high.
// Ports:
//   state_in    [0:127] current state, byte i at bits [8i:8i+7], column-major
//   round_key   [0:127] key for this round, same byte order
//   final_round 1       skip MixColumns
//   state_out   [0:127] next state
// -----------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [0:AES_BLK_W-1] state_in,
    input  logic [0:AES_BLK_W-1] round_key,
    input  logic                 final_round,
    output logic [0:AES_BLK_W-1] state_out
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    always_comb begin
        sb = '{default: '0};
        sr = '{default: '0};
        mc = '{default: '0};
        state_out = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sb[i] = sbox(state_in[i*8 +: 8]);
        end
        // Byte index is row + 4*column; row r rotates left by r columns.
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc[4*c]     = gf_mul2(sr[4*c]) ^ gf_mul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c + 1] = sr[4*c] ^ gf_mul2(sr[4*c+1]) ^ gf_mul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c + 2] = sr[4*c] ^ sr[4*c+1] ^ gf_mul2(sr[4*c+2]) ^ gf_mul3(sr[4*c+3]);
            mc[4*c + 3] = gf_mul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            state_out[i*8 +: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[i*8 +: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_core.sv
// -----------------------------------------------------------------------------
// aes_cipher_core
// Iterative AES-128 encryption, one round per clock (11 cycles per block).
// Optional feature macro: AES_CIPHER_OUT_HANDSHAKE_EN adds out_ready and
// holds out_valid/ciphertext until acknowledged.
// Ports:
//   CLK         1        clock, rising edge
//   RST         1        synchronous active-high reset
//   start       1        encrypt plaintext (accepted only when idle and keys_valid)
//   plaintext   [0:127]  input block, byte 0 at bits [0:7]
//   round_keys  [0:1407] round key r at [r*128 +: 128]
//   keys_valid  1        round_keys stable and valid
//   out_ready   1        (handshake build only) result acknowledge
//   ciphertext  [0:127]  result block, held until the next result
//   out_valid   1        result strobe
//   busy        1        encryption in progress
// -----------------------------------------------------------------------------
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int unsigned NR = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [0:AES_BLK_W-1] plaintext,
    input  logic [0:AES_RK_W-1]  round_keys,
    input  logic                 keys_valid,
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
    input  logic                 out_ready,
`endif
    output logic [0:AES_BLK_W-1] ciphertext,
    output logic                 out_valid,
    output logic                 busy
);

    if (NR != AES_NR) begin : g_nr_check
        $error("aes_cipher_core: NR must be 10 for AES-128");
    end

    fsm_t                 fsm;
    logic [0:AES_BLK_W-1] state;
    logic [3:0]           count;
    logic [10:0]          rk_base;
    logic [0:AES_BLK_W-1] rk_sel;
    logic [0:AES_BLK_W-1] round_out;
    logic                 final_round;

    // count already equals NR in FINAL, so one key mux serves every round.
    always_comb begin
        rk_base     = {count, 7'd0};
        rk_sel      = round_keys[rk_base +: AES_BLK_W];
        final_round = (fsm == FINAL);
    end

    aes_round u_round (
        .state_in    (state),
        .round_key   (rk_sel),
        .final_round (final_round),
        .state_out   (round_out)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm        <= IDLE;
            state      <= '0;
            count      <= '0;
            ciphertext <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
`ifndef AES_CIPHER_OUT_HANDSHAKE_EN
            out_valid <= 1'b0;
`endif
            case (fsm)
                IDLE: begin
                    if (start && keys_valid) begin
                        state <= plaintext ^ round_keys[0 +: AES_BLK_W];
                        count <= 4'd1;
                        busy  <= 1'b1;
                        fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    state <= round_out;
                    count <= count + 4'd1;
                    // The round just applied used rk[NR-1]; the last one is next.
                    if (count == 4'(NR - 1)) begin
                        fsm <= FINAL;
                    end
                end
                FINAL: begin
                    ciphertext <= round_out;
                    out_valid  <= 1'b1;
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
                    fsm        <= HOLD;
`else
                    busy       <= 1'b0;
                    fsm        <= IDLE;
`endif
                end
                HOLD: begin
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        fsm       <= IDLE;
                    end
`else
                    fsm <= IDLE;
`endif
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_core.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_core
// Bench for aes_cipher_core. Holds a byte-matrix AES-128 reference (S-box
// derived from the GF(2^8) inverse and affine map, key expansion, rounds) and
// a transaction-level model of busy/out_valid/ciphertext compared every cycle,
// plus literal FIPS-197 vectors. Honours AES_CIPHER_OUT_HANDSHAKE_EN.
// -----------------------------------------------------------------------------
module tb_aes_cipher_core;

    logic           CLK = 1'b0;
    logic           RST;
    logic           start;
    logic [0:127]   plaintext;
    logic [0:1407]  round_keys;
    logic           keys_valid;
    logic [0:127]   ciphertext;
    logic           out_valid;
    logic           busy;
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
    logic           out_ready;
    localparam int B2B_HOLD = 2;
    localparam int B2B_LAT  = 12;
`else
    localparam int B2B_HOLD = 1;
    localparam int B2B_LAT  = 11;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    bit          cmp_en  = 1'b0;

    localparam logic [0:127] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] R1_2 = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [0:127] JUNK = 128'hdeadbeef0123456789abcdeffedcba98;

    always #5 CLK = ~CLK;

    aes_cipher_core #(.NR(10)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .keys_valid (keys_valid),
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
        .out_ready  (out_ready),
`endif
        .ciphertext (ciphertext),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    // ---------------- reference AES ----------------
    logic [7:0] tb_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        logic [15:0] t = {b, b};
        t = t << k;
        return t[15:8];
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = '0;
            logic [7:0] s;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = 8'h63;
            for (int k = 0; k < 5; k++) s = s ^ rotl8(inv, k);
            tb_sbox[a] = s;
        end
    endtask

    function automatic logic [0:1407] key_expand(input logic [0:127] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon = 8'h01;
        logic [0:1407] res;
        for (int i = 0; i < 4; i++) w[i] = key[i*32 +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) res[i*32 +: 32] = w[i];
        return res;
    endfunction

    function automatic logic [0:127] model_encrypt(input logic [0:1407] rk, input logic [0:127] pt,
                                                   output logic [0:127] r1);
        logic [7:0]   st [4][4];
        logic [7:0]   t  [4][4];
        logic [7:0]   a  [4];
        logic [0:127] res;
        r1 = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = pt[(4*c+r)*8 +: 8] ^ rk[(4*c+r)*8 +: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = tb_sbox[st[r][(c+r)%4]];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = t[r][c];
                    for (int r = 0; r < 4; r++)
                        t[r][c] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    st[r][c] = t[r][c] ^ rk[rnd*128 + (4*c+r)*8 +: 8];
            if (rnd == 1)
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) r1[(4*c+r)*8 +: 8] = st[r][c];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) res[(4*c+r)*8 +: 8] = st[r][c];
        return res;
    endfunction

    // ---------------- transaction model ----------------
    logic         m_busy = 1'b0;
    logic         m_ov   = 1'b0;
    logic         m_hold = 1'b0;
    logic         m_acc;
    logic [0:127] m_ct   = '0;
    logic [0:127] m_pend = '0;
    logic [0:127] m_dummy;
    int           m_left = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_busy = 1'b0; m_ov = 1'b0; m_hold = 1'b0; m_ct = '0; m_left = 0;
        end else begin
            m_acc = start && keys_valid && !m_busy;
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
            if (m_hold && out_ready) begin
                m_hold = 1'b0; m_ov = 1'b0; m_busy = 1'b0;
            end
`else
            m_ov = 1'b0;
`endif
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_ov = 1'b1;
                    m_ct = m_pend;
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
                    m_hold = 1'b1;
`else
                    m_busy = 1'b0;
`endif
                end
            end
            if (m_acc) begin
                m_busy = 1'b1;
                m_left = 10;
                m_pend = model_encrypt(round_keys, plaintext, m_dummy);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_out_valid", out_valid, m_ov);
            check("cyc_ciphertext", ciphertext, m_ct);
        end
    end

    // ---------------- directed tests ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_one(input logic [0:127] pt, input logic [0:127] exp_ct, input string name,
                           input bit chk_r1, input logic [0:127] exp_r1);
        int n = 0;
        bit got = 1'b0;
        plaintext = pt;
        start = 1'b1;
        while (n < 30 && !got) begin
            tick();
            n++;
            start = 1'b0;
            if (chk_r1 && n == 2) check({name, "_round1"}, dut.state, exp_r1);
            got = out_valid;
        end
        check({name, "_latency"}, 128'(n), 128'd11);
        check({name, "_ct"}, ciphertext, exp_ct);
        tick();
        check({name, "_pulse_width"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [0:1407] rk1, rk2;
        logic [0:127]  r1, ct;
        int            pulses, first_n, cnt;

        RST = 1'b1; start = 1'b0; keys_valid = 1'b0; plaintext = '0; round_keys = '0;
`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
        out_ready = 1'b1;
`endif
        build_sbox();
        rk1 = key_expand(KEY1);
        rk2 = key_expand(KEY2);

        // Pin the reference itself.
        check("model_sbox_00", tb_sbox[8'h00], 8'h63);
        check("model_sbox_53", tb_sbox[8'h53], 8'hed);
        check("model_rk10_key1", rk1[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("model_rk10_key2", rk2[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        ct = model_encrypt(rk1, PT1, r1);
        check("model_ct1", ct, CT1);
        ct = model_encrypt(rk2, PT2, r1);
        check("model_ct2", ct, CT2);
        check("model_round1", r1, R1_2);

        tick();
        cmp_en = 1'b1;
        tick();
        check("reset_busy", busy, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_ciphertext", ciphertext, 128'h0);
        RST = 1'b0;
        tick();

        // FIPS-197 appendix C.1 vector.
        round_keys = rk1; keys_valid = 1'b1;
        run_one(PT1, CT1, "c1", 1'b0, '0);

        // Appendix B vector with first-round state.
        round_keys = rk2;
        run_one(PT2, CT2, "b", 1'b1, R1_2);

        // Start without valid keys is dropped.
        keys_valid = 1'b0; start = 1'b1; plaintext = PT1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (busy || out_valid) cnt++;
        end
        check("nokeys_idle_cycles", 128'(cnt), 128'd0);
        keys_valid = 1'b1;
        run_one(PT2, CT2, "after_nokeys", 1'b0, '0);

        // Starts while busy ignored; start on the out_valid cycle accepted.
        plaintext = PT2; start = 1'b1;
        pulses = 0; first_n = 0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    first_n = n;
                    check("busy_ign_latency", 128'(n), 128'd11);
                    check("busy_ign_ct", ciphertext, CT2);
                end else if (pulses == 2) begin
                    check("b2b_latency", 128'(n - first_n), 128'(B2B_LAT));
                    check("b2b_ct", ciphertext, CT2);
                end
            end
            start = (n == 3 || n == 7 || (first_n != 0 && n - first_n < B2B_HOLD));
            plaintext = (n == 3 || n == 7) ? JUNK : PT2;
        end
        start = 1'b0;
        check("b2b_pulse_count", 128'(pulses), 128'd2);

        // Reset in the middle of an encryption.
        round_keys = rk1; plaintext = PT1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_ciphertext", ciphertext, 128'h0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("midrst_no_late_valid", 128'(cnt), 128'd0);
        run_one(PT1, CT1, "after_rst", 1'b0, '0);

`ifdef AES_CIPHER_OUT_HANDSHAKE_EN
        // Result held until acknowledged; starts ignored while held.
        out_ready = 1'b0; plaintext = PT1; start = 1'b1;
        cnt = 0;
        while (cnt < 30 && !out_valid) begin
            tick();
            cnt++;
            start = 1'b0;
        end
        check("hs_latency", 128'(cnt), 128'd11);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1; plaintext = JUNK;
            tick();
            check("hs_hold_valid", out_valid, 1'b1);
            check("hs_hold_busy", busy, 1'b1);
            check("hs_hold_ct", ciphertext, CT1);
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
        check("hs_ack_valid", out_valid, 1'b0);
        check("hs_ack_busy", busy, 1'b0);
        tick();
        check("hs_idle_busy", busy, 1'b0);
`endif

        repeat (3) tick();
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
